// File: rtl/branch_predictor_if.sv
// Purpose : fetch/execute-side bundle of the branch predictor (lookup, training, redirect, stats).
// Latency : lookup signals are same-cycle; redirect and stats are registered one edge after update.
// Backpressure: none; an update is consumed on every edge where upd_valid_i is high.
// Members keep the predictor's own port names: *_i are driven by the master (pipeline),
// *_o are driven by the slave (predictor).
interface branch_predictor_if #(
    parameter int XLEN   = 32,
    parameter int STAT_W = 32
);
    logic [XLEN-1:0]   fetch_pc_i;
    logic              pred_taken_o;
    logic [XLEN-1:0]   pred_addr_o;
    logic              upd_valid_i;
    logic [XLEN-1:0]   upd_pc_i;
    logic              upd_taken_i;
    logic [XLEN-1:0]   upd_target_i;
    logic              upd_pred_taken_i;
    logic [XLEN-1:0]   upd_pred_addr_i;
    logic              invalidate_i;
    logic              mispredict_o;
    logic [XLEN-1:0]   redirect_addr_o;
    logic [STAT_W-1:0] stat_branches_o;
    logic [STAT_W-1:0] stat_mispredicts_o;

    modport master (
        output fetch_pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
               upd_pred_taken_i, upd_pred_addr_i, invalidate_i,
        input  pred_taken_o, pred_addr_o, mispredict_o, redirect_addr_o,
               stat_branches_o, stat_mispredicts_o
    );

    modport slave (
        input  fetch_pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
               upd_pred_taken_i, upd_pred_addr_i, invalidate_i,
        output pred_taken_o, pred_addr_o, mispredict_o, redirect_addr_o,
               stat_branches_o, stat_mispredicts_o
    );
endinterface

// File: rtl/branch_predictor.sv
// Purpose : direct-mapped BTB with per-entry saturating direction counters, mispredict flag, stats.
// Latency : 0-cycle lookup; mispredict/redirect/stats registered 1 cycle after the update.
// Backpressure: none; every upd_valid_i edge is trained and counted.
// Ports: clk_i/rst_i (async active-high reset); bp = slave side of branch_predictor_if
// carrying the fetch lookup, the execute-stage update, invalidate and the registered outputs.
module branch_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int CNT_W   = 2,
    parameter int STAT_W  = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    branch_predictor_if.slave    bp
);
    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX - 2;

    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t CNT_MAX = '1;
    localparam cnt_t CNT_WNT = cnt_t'((2 ** (CNT_W - 1)) - 1);  // weakly not-taken
    localparam cnt_t CNT_WT  = cnt_t'(2 ** (CNT_W - 1));        // weakly taken

    logic [ENTRIES-1:0] valid_q, valid_d;
    cnt_t               cnt_q    [ENTRIES];
    cnt_t               cnt_d    [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    logic [XLEN-1:0]    target_d [ENTRIES];

    logic              mispredict_q, mispredict_d;
    logic [XLEN-1:0]   redirect_q, redirect_d;
    logic [STAT_W-1:0] br_cnt_q, br_cnt_d;
    logic [STAT_W-1:0] mp_cnt_q, mp_cnt_d;

    logic [IDX-1:0]   f_idx, u_idx;
    logic [TAG_W-1:0] f_tag, u_tag;
    logic             f_hit, u_hit, mis_cond;

    // Low two PC bits are never used for indexing or tagging.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp.fetch_pc_i[1:0], bp.upd_pc_i[1:0]};

    assign f_idx = bp.fetch_pc_i[IDX+1:2];
    assign f_tag = bp.fetch_pc_i[XLEN-1:IDX+2];
    assign u_idx = bp.upd_pc_i[IDX+1:2];
    assign u_tag = bp.upd_pc_i[XLEN-1:IDX+2];

    // Lookup reads only the registered table, so a same-cycle update is seen next cycle.
    assign f_hit           = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign bp.pred_taken_o = f_hit && cnt_q[f_idx][CNT_W-1];
    assign bp.pred_addr_o  = bp.pred_taken_o ? target_q[f_idx] : bp.fetch_pc_i + XLEN'(4);

    assign u_hit    = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign mis_cond = bp.upd_valid_i &&
                      ((bp.upd_taken_i != bp.upd_pred_taken_i) ||
                       (bp.upd_taken_i && (bp.upd_target_i != bp.upd_pred_addr_i)));

    always_comb begin
        valid_d  = valid_q;
        cnt_d    = cnt_q;
        tag_d    = tag_q;
        target_d = target_q;
        if (bp.upd_valid_i) begin
            if (u_hit) begin
                if (bp.upd_taken_i) begin
                    if (cnt_q[u_idx] != CNT_MAX) cnt_d[u_idx] = cnt_q[u_idx] + cnt_t'(1);
                    target_d[u_idx] = bp.upd_target_i;
                end else if (cnt_q[u_idx] != '0) begin
                    cnt_d[u_idx] = cnt_q[u_idx] - cnt_t'(1);
                end
            end else if (bp.upd_taken_i) begin
                valid_d[u_idx]  = 1'b1;
                tag_d[u_idx]    = u_tag;
                target_d[u_idx] = bp.upd_target_i;
                cnt_d[u_idx]    = CNT_WT;
            end
        end
        // Flush wins over a concurrent allocation; leftover counters are harmless
        // because allocation re-seeds them.
        if (bp.invalidate_i) valid_d = '0;
    end

    always_comb begin
        mispredict_d = mis_cond;
        redirect_d   = redirect_q;
        if (mis_cond) redirect_d = bp.upd_taken_i ? bp.upd_target_i : bp.upd_pc_i + XLEN'(4);
        br_cnt_d = br_cnt_q;
        mp_cnt_d = mp_cnt_q;
        if (bp.upd_valid_i && (br_cnt_q != '1)) br_cnt_d = br_cnt_q + STAT_W'(1);
        if (mis_cond && (mp_cnt_q != '1))       mp_cnt_d = mp_cnt_q + STAT_W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_WNT;
            mispredict_q <= 1'b0;
            redirect_q   <= '0;
            br_cnt_q     <= '0;
            mp_cnt_q     <= '0;
        end else begin
            valid_q      <= valid_d;
            cnt_q        <= cnt_d;
            mispredict_q <= mispredict_d;
            redirect_q   <= redirect_d;
            br_cnt_q     <= br_cnt_d;
            mp_cnt_q     <= mp_cnt_d;
        end
    end

    // Tag and target contents are qualified by valid, so they carry no reset.
    always_ff @(posedge clk_i) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

    assign bp.mispredict_o       = mispredict_q;
    assign bp.redirect_addr_o    = redirect_q;
    assign bp.stat_branches_o    = br_cnt_q;
    assign bp.stat_mispredicts_o = mp_cnt_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Purpose : directed self-checking bench for branch_predictor (main instance + 4-bit stats instance).
// Latency : checks combinational lookup same cycle, registered outputs 1 ns after the update edge.
// Backpressure: none exercised; the predictor accepts every update.
module tb_branch_predictor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_predictor_if #(.XLEN(32), .STAT_W(32)) bus_a ();
    branch_predictor_if #(.XLEN(32), .STAT_W(4))  bus_b ();

    branch_predictor #(.XLEN(32), .ENTRIES(64), .CNT_W(2), .STAT_W(32)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .bp(bus_a)
    );
    branch_predictor #(.XLEN(32), .ENTRIES(64), .CNT_W(2), .STAT_W(4)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .bp(bus_b)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic look(input string tag, input logic [31:0] pc,
                        input logic exp_t, input logic [31:0] exp_a);
        bus_a.fetch_pc_i = pc;
        #1;
        chk({tag, "_taken"}, 64'(bus_a.pred_taken_o), 64'(exp_t));
        chk({tag, "_addr"},  64'(bus_a.pred_addr_o),  64'(exp_a));
    endtask

    // Drives one update for one edge, returns 1 ns after that edge.
    task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                       input logic ptaken, input logic [31:0] paddr, input logic inv);
        bus_a.upd_valid_i      = 1'b1;
        bus_a.upd_pc_i         = pc;
        bus_a.upd_taken_i      = taken;
        bus_a.upd_target_i     = tgt;
        bus_a.upd_pred_taken_i = ptaken;
        bus_a.upd_pred_addr_i  = paddr;
        bus_a.invalidate_i     = inv;
        @(posedge clk);
        #1;
        bus_a.upd_valid_i  = 1'b0;
        bus_a.invalidate_i = 1'b0;
    endtask

    task automatic regs(input string tag, input logic mp, input logic [31:0] redir,
                        input int br, input int mps);
        chk({tag, "_mispredict"}, 64'(bus_a.mispredict_o),       64'(mp));
        chk({tag, "_redirect"},   64'(bus_a.redirect_addr_o),    64'(redir));
        chk({tag, "_branches"},   64'(bus_a.stat_branches_o),    64'(br));
        chk({tag, "_mispreds"},   64'(bus_a.stat_mispredicts_o), 64'(mps));
    endtask

    initial begin
        bus_a.fetch_pc_i = 32'h100;
        bus_a.upd_valid_i = 1'b0; bus_a.upd_pc_i = '0; bus_a.upd_taken_i = 1'b0;
        bus_a.upd_target_i = '0; bus_a.upd_pred_taken_i = 1'b0; bus_a.upd_pred_addr_i = '0;
        bus_a.invalidate_i = 1'b0;
        bus_b.fetch_pc_i = '0;
        bus_b.upd_valid_i = 1'b0; bus_b.upd_pc_i = 32'h10; bus_b.upd_taken_i = 1'b0;
        bus_b.upd_target_i = '0; bus_b.upd_pred_taken_i = 1'b1; bus_b.upd_pred_addr_i = '0;
        bus_b.invalidate_i = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        look("rst_lookup", 32'h100, 1'b0, 32'h104);
        regs("rst", 1'b0, 32'h0, 0, 0);
        chk("rst_b_branches", 64'(bus_b.stat_branches_o), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // First taken branch allocates, flags mispredict
        upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104, 1'b0);
        regs("alloc", 1'b1, 32'h200, 1, 1);
        look("alloc_lookup", 32'h100, 1'b1, 32'h200);
        @(posedge clk);
        #1;
        chk("pulse_drop", 64'(bus_a.mispredict_o), 64'd0);

        // Saturate at 11, then two not-taken steps: 10 still taken, 01 not taken
        for (int i = 0; i < 3; i++) upd(32'h100, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0);
        regs("sat", 1'b0, 32'h200, 4, 1);
        upd(32'h100, 1'b0, 32'h200, 1'b1, 32'h200, 1'b0);
        regs("nt1", 1'b1, 32'h104, 5, 2);
        look("nt1_lookup", 32'h100, 1'b1, 32'h200);
        upd(32'h100, 1'b0, 32'h200, 1'b1, 32'h200, 1'b0);
        regs("nt2", 1'b1, 32'h104, 6, 3);
        look("nt2_lookup", 32'h100, 1'b0, 32'h104);

        // Alias: 0x100 and 0x200 share index 0 with different tags
        upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104, 1'b0);
        look("pre_alias", 32'h100, 1'b1, 32'h200);
        upd(32'h200, 1'b1, 32'h300, 1'b0, 32'h204, 1'b0);
        regs("alias", 1'b1, 32'h300, 8, 5);
        look("alias_old", 32'h100, 1'b0, 32'h104);
        look("alias_new", 32'h200, 1'b1, 32'h300);

        // Correct predictions leave mispredict low and redirect held
        upd(32'h104, 1'b1, 32'h200, 1'b0, 32'h108, 1'b0);
        regs("alloc104", 1'b1, 32'h200, 9, 6);
        upd(32'h200, 1'b1, 32'h300, 1'b1, 32'h300, 1'b0);
        regs("hold", 1'b0, 32'h200, 10, 6);
        upd(32'h104, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0);
        regs("correct", 1'b0, 32'h200, 11, 6);
        upd(32'h104, 1'b1, 32'h240, 1'b1, 32'h200, 1'b0);
        regs("tgt_change", 1'b1, 32'h240, 12, 7);
        look("tgt_lookup", 32'h104, 1'b1, 32'h240);
        look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

        // Invalidate beats a concurrent allocation; stats still count it
        upd(32'h300, 1'b1, 32'h400, 1'b0, 32'h304, 1'b1);
        regs("inv", 1'b1, 32'h400, 13, 8);
        look("inv_300", 32'h300, 1'b0, 32'h304);
        look("inv_200", 32'h200, 1'b0, 32'h204);
        look("inv_104", 32'h104, 1'b0, 32'h108);

        // Reset in the middle of a pulse, no clock edge in between
        upd(32'h100, 1'b1, 32'h500, 1'b0, 32'h104, 1'b0);
        chk("pre_rst_pulse", 64'(bus_a.mispredict_o), 64'd1);
        #1 rst = 1'b1;
        #1;
        regs("async_rst", 1'b0, 32'h0, 0, 0);
        look("async_rst_lookup", 32'h100, 1'b0, 32'h104);
        @(negedge clk);
        rst = 1'b0;

        // 4-bit stats saturate at 15
        @(posedge clk);
        #1;
        bus_b.upd_valid_i = 1'b1;
        for (int i = 0; i < 14; i++) @(posedge clk);
        #1;
        chk("stat4_14_branches", 64'(bus_b.stat_branches_o),    64'd14);
        chk("stat4_14_mispreds", 64'(bus_b.stat_mispredicts_o), 64'd14);
        for (int i = 0; i < 3; i++) @(posedge clk);
        #1;
        bus_b.upd_valid_i = 1'b0;
        chk("stat4_17_branches", 64'(bus_b.stat_branches_o),    64'd15);
        chk("stat4_17_mispreds", 64'(bus_b.stat_mispredicts_o), 64'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised successor to the combinational branch-resolution logic: a direct-mapped branch target buffer with per-entry 2-bit saturating direction counters.
- Fetch performs a same-cycle lookup to obtain predicted direction and target.
- Execute reports each resolved branch/jump; the block trains its tables, flags a registered mispredict/redirect to fetch, and keeps saturating performance counters.

Parameters:
- XLEN, 32, address/data width.
- ENTRIES, 64, BTB entries; power of two, ≥2.
- CNT_W, 2, direction counter width; ≥1.
- STAT_W, 32, statistics counter width.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- fetch_pc_i  in  XLEN  PC being fetched.
- pred_taken_o  out  1  predicted taken (combinational).
- pred_addr_o  out  XLEN  predicted next PC (combinational).
- upd_valid_i  in  1  resolved control-flow instruction this cycle.
- upd_pc_i  in  XLEN  PC of resolved instruction.
- upd_taken_i  in  1  actual direction.
- upd_target_i  in  XLEN  actual target (base + offset).
- upd_pred_taken_i  in  1  direction predicted when fetched.
- upd_pred_addr_i  in  XLEN  next PC predicted when fetched.
- invalidate_i  in  1  clear all BTB entries (fence.i / context flush).
- mispredict_o  out  1  registered; one-cycle pulse.
- redirect_addr_o  out  XLEN  registered; correct next PC.
- stat_branches_o  out  STAT_W  resolved updates count.
- stat_mispredicts_o  out  STAT_W  mispredict count.

Behaviour:
- IDX = log2(ENTRIES). Index = pc[IDX+1:2]; tag = pc[XLEN-1:IDX+2]; pc[1:0] ignored.
- Entry = {valid, tag, target, counter}. Taken prediction = counter MSB.
- Reset (async, immediate): all valid=0, counters = 2^(CNT_W-1)-1 (weakly not-taken, 01 for CNT_W=2), mispredict_o=0, redirect_addr_o=0, both stats=0. Tags/targets need not be reset.
- Lookup (0-cycle, combinational): hit = valid & tag match. pred_taken_o = hit & counter MSB. pred_addr_o = pred_taken_o ? target : fetch_pc_i+4 (mod 2^XLEN).
- Update, on edge with upd_valid_i=1:
  - Hit: counter +1 if taken, -1 if not, saturating at 0 and 2^CNT_W-1; if taken, target := upd_target_i.
  - Miss and taken: allocate/overwrite slot; valid=1, tag, target, counter = 2^(CNT_W-1) (weakly taken).
  - Miss and not taken: no table change.
- Mispredict condition: upd_valid_i & ((upd_taken_i != upd_pred_taken_i) | (upd_taken_i & upd_target_i != upd_pred_addr_i)).
  - Registered next cycle: mispredict_o = condition; redirect_addr_o = upd_taken_i ? upd_target_i : upd_pc_i+4.
  - redirect_addr_o holds its value when mispredict_o=0.
- Stats: stat_branches_o +1 per upd_valid_i; stat_mispredicts_o +1 per mispredict condition. Both update on the same edge as mispredict_o and saturate at all-ones (no wrap).
- Simultaneous lookup and update to the same index: lookup returns pre-update contents; the new value is visible from the next cycle.
- invalidate_i: all valid := 0 on the edge. It takes precedence over a same-cycle table update. Stats and mispredict detection still process that update.
- Reset mid-operation clears a pending mispredict pulse immediately.

Test Plan:
- Reset, fetch_pc_i=0x100 → pred_taken_o=0, pred_addr_o=0x104, stats=0, mispredict_o=0.
- Update pc=0x100, taken, target=0x200, pred_taken=0 → next cycle mispredict_o=1, redirect_addr_o=0x200, stats 1/1. Lookup 0x100 then gives taken, 0x200.
- Update pc=0x100 three times taken → counter saturates at 11. One not-taken update → 10, still predicts 0x200. Second not-taken → 01, predicts 0x104.
- Alias: ENTRIES=64, update 0x100 taken then 0x200 (same index, different tag) taken to 0x300 → lookup 0x100 misses (0x104); lookup 0x200 returns 0x300.
- Correct prediction: pred_taken=1, pred_addr=0x200, actual taken to 0x200 → mispredict_o=0, stat_branches_o increments only. Then target changes to 0x240 with predicted 0x200 → mispredict_o=1, redirect_addr_o=0x240.
- Edge cases:
  - Stats preloaded near STAT_W max (or STAT_W=4 with 17 updates) → saturate at 15.
  - invalidate_i with a concurrent taken update → all lookups miss next cycle.
  - rst_i asserted mid-pulse → mispredict_o drops without a clock edge.
